spike_encoder: RTL and testbench

- Upstream neighbour of the synaptic controller.
- Captures one N-bit input spike frame and serialises it into 6-bit run-length tokens, one token per cycle under valid/ready.
- Token layout: enc[5] is the chunk-end flag; enc[4:0] is the address delta.
- The frame is processed as N/32 chunks of 32 bits. Downstream adds enc[4:0] plus enc[5] to its synapse read address and counts end tokens to detect frame completion.

---
 rtl/spike_encoder.sv | 149 ++++++++++++++
 tb/tb_spike_encoder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/spike_encoder.sv
// spike_encoder: serialises one N-bit spike frame into 6-bit run-length tokens ({chunk_end, delta}).
// Latency: first token valid the cycle after frame acceptance; one token per cycle thereafter.
// Backpressure: opt_ready=0 freezes all state so enc/opt_valid hold; ipt_ready is low for the whole frame.
//
// Ports:
//   clk, rst_n            - clock (rising edge) and asynchronous active-low reset
//   ipt_spk/ipt_valid     - input spike frame, bit i = presynaptic neuron i fired
//   ipt_ready             - high only while idle (ready to capture a new frame)
//   enc/opt_valid         - token output: enc[5] chunk end, enc[4:0] address delta
//   opt_ready             - downstream accepts the current token
// Optional build macro SPIKE_ENC_POPCNT_EN adds frame_spk_cnt/frame_done, a per-frame
// spike count reported with a single-cycle done pulse on the frame's last end token.
//
// N must be a multiple of 32 and at least 32.
module spike_encoder #(
    parameter int N = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] ipt_spk,
    input  logic         ipt_valid,
    output logic         ipt_ready,
    output logic [5:0]   enc,
    output logic         opt_valid,
    input  logic         opt_ready
`ifdef SPIKE_ENC_POPCNT_EN
    ,
    output logic [$clog2(N+1)-1:0] frame_spk_cnt,
    output logic                   frame_done
`endif
);

    localparam int CHUNK_NUM = N / 32;
    localparam int CIDX_WID  = (CHUNK_NUM > 1) ? $clog2(CHUNK_NUM) : 1;
    localparam logic [CIDX_WID-1:0] CIDX_LAST = CIDX_WID'(CHUNK_NUM - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]          state;
    logic [N-1:0]        frame;
    logic [31:0]         mask;      // spikes of the current chunk not yet emitted
    logic [4:0]          ptr;       // bit position of the last emitted spike in this chunk
    logic [CIDX_WID-1:0] cidx;
    logic [CIDX_WID-1:0] cidx_nxt;

    logic [4:0] low_idx;
    logic       mask_empty;
    logic       ipt_hs;
    logic       opt_hs;
    logic       last_chunk;

    // Lowest set bit of the mask; scanning downward lets the lowest hit win.
    always_comb begin
        low_idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (mask[i]) begin
                low_idx = 5'(i);
            end
        end
    end

    assign mask_empty = (mask == 32'd0);
    assign last_chunk = (cidx == CIDX_LAST);
    assign cidx_nxt   = cidx + 1'b1;

    assign ipt_ready = (state == ST_IDLE);
    assign opt_valid = (state == ST_RUN);
    assign ipt_hs    = ipt_valid & ipt_ready;
    assign opt_hs    = opt_valid & opt_ready;

    // Token is derived only from registered state, so it cannot change while stalled.
    // low_idx >= ptr always holds, so the 5-bit subtraction never wraps.
    always_comb begin
        enc = 6'h00;
        if (state == ST_RUN) begin
            if (mask_empty) begin
                enc = {1'b1, 5'd31 - ptr};
            end else begin
                enc = {1'b0, low_idx - ptr};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            frame <= '0;
            mask  <= '0;
            ptr   <= '0;
            cidx  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ipt_hs) begin
                        frame <= ipt_spk;
                        mask  <= ipt_spk[31:0];
                        ptr   <= '0;
                        cidx  <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (opt_hs) begin
                        if (!mask_empty) begin
                            mask[low_idx] <= 1'b0;
                            ptr           <= low_idx;
                        end else begin
                            ptr <= '0;
                            if (last_chunk) begin
                                state <= ST_IDLE;
                            end else begin
                                cidx <= cidx_nxt;
                                mask <= frame[{cidx_nxt, 5'd0} +: 32];
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SPIKE_ENC_POPCNT_EN
    localparam int CNT_WID = $clog2(N + 1);

    logic [CNT_WID-1:0] spk_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spk_cnt       <= '0;
            frame_spk_cnt <= '0;
            frame_done    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (opt_hs) begin
                if (!mask_empty) begin
                    spk_cnt <= spk_cnt + 1'b1;
                end else if (last_chunk) begin
                    frame_spk_cnt <= spk_cnt;
                    frame_done    <= 1'b1;
                    spk_cnt       <= '0;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_spike_encoder.sv
// tb_spike_encoder: randomized self-checking bench for spike_encoder.
// Expected tokens come from a per-chunk run-length model of the frame.
// Optional counter ports are checked when SPIKE_ENC_POPCNT_EN is defined.
module tb_spike_encoder;

    localparam int N         = 128;
    localparam int CHUNK_NUM = N / 32;
    localparam int MAX_CYC   = 4000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] ipt_spk;
    logic         ipt_valid;
    logic         ipt_ready;
    logic [5:0]   enc;
    logic         opt_valid;
    logic         opt_ready;
`ifdef SPIKE_ENC_POPCNT_EN
    logic [$clog2(N+1)-1:0] frame_spk_cnt;
    logic                   frame_done;
`endif

    always #5 clk = ~clk;

    spike_encoder #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ipt_spk   (ipt_spk),
        .ipt_valid (ipt_valid),
        .ipt_ready (ipt_ready),
        .enc       (enc),
        .opt_valid (opt_valid),
        .opt_ready (opt_ready)
`ifdef SPIKE_ENC_POPCNT_EN
        ,
        .frame_spk_cnt (frame_spk_cnt),
        .frame_done    (frame_done)
`endif
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [5:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int popcnt(input logic [N-1:0] f);
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(f[i]);
        return c;
    endfunction

    // Reference: in each chunk every spike emits its distance from the previous
    // spike (or from bit 0), and the chunk closes with an end token covering the
    // remaining distance so the chunk totals 32 positions.
    task automatic build_exp(input logic [N-1:0] f);
        exp_q.delete();
        for (int c = 0; c < CHUNK_NUM; c++) begin
            int prev = 0;
            for (int b = 0; b < 32; b++) begin
                if (f[32*c + b]) begin
                    exp_q.push_back(6'(b - prev));
                    prev = b;
                end
            end
            exp_q.push_back(6'(32 + 31 - prev));
        end
    endtask

    // Sends one frame and collects tokens. stall randomizes opt_ready, junk keeps
    // ipt_valid high with a different frame while the encoder is busy, and
    // max_tok stops collection early (used for the mid-frame reset case).
    task automatic run_frame(input logic [N-1:0] f, input bit stall, input bit junk,
                             input int max_tok);
        int         got     = 0;
        int         cyc     = 0;
        int         total;
        bit         stalled = 1'b0;
        logic [5:0] held    = 6'h00;
        build_exp(f);
        total = exp_q.size();
        @(negedge clk);
        check("idle_ready", 32'(ipt_ready), 32'd1);
        ipt_spk   = f;
        ipt_valid = 1'b1;
        @(negedge clk);
        ipt_spk   = ~f;
        ipt_valid = 1'b0;
        check("first_tok_valid", 32'(opt_valid), 32'd1);
        check("run_ready_low", 32'(ipt_ready), 32'd0);
        while (got < total && got < max_tok && cyc < MAX_CYC) begin
            if (stalled) begin
                check("stall_enc_stable", 32'(enc), 32'(held));
                check("stall_vld_held", 32'(opt_valid), 32'd1);
            end
            ipt_valid = junk && (got < total - 1);
            opt_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (opt_valid && opt_ready) begin
                check($sformatf("tok%0d", got), 32'(enc), 32'(exp_q[got]));
                got++;
                stalled = 1'b0;
            end else begin
                stalled = opt_valid;
                held    = enc;
            end
            @(negedge clk);
            cyc++;
        end
        opt_ready = 1'b0;
        ipt_valid = 1'b0;
        if (cyc >= MAX_CYC) check("token_timeout", 32'd1, 32'd0);
        if (got == total) begin
            if (!stall) check("frame_cycles", 32'(cyc), 32'(total));
            check("end_idle_ready", 32'(ipt_ready), 32'd1);
            check("end_valid_low", 32'(opt_valid), 32'd0);
            check("end_enc_zero", 32'(enc), 32'd0);
`ifdef SPIKE_ENC_POPCNT_EN
            check("frame_done_pulse", 32'(frame_done), 32'd1);
            check("frame_spk_cnt", 32'(frame_spk_cnt), 32'(popcnt(f)));
            @(negedge clk);
            check("frame_done_one_cycle", 32'(frame_done), 32'd0);
`endif
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [N-1:0] f1;
    logic [N-1:0] fr;

    initial begin
        rst_n     = 1'b0;
        ipt_valid = 1'b0;
        opt_ready = 1'b0;
        ipt_spk   = '0;
        #23;
        check("in_reset_valid", 32'(opt_valid), 32'd0);
        check("in_reset_ready", 32'(ipt_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_valid", 32'(opt_valid), 32'd0);
        check("idle_ready", 32'(ipt_ready), 32'd1);
        check("idle_enc", 32'(enc), 32'd0);
`ifdef SPIKE_ENC_POPCNT_EN
        check("reset_cnt", 32'(frame_spk_cnt), 32'd0);
        check("reset_done", 32'(frame_done), 32'd0);
`endif

        // Empty frame: one 0x3F per chunk.
        run_frame('0, 1'b0, 1'b0, 1000);

        f1 = '0;
        f1[0] = 1'b1; f1[5] = 1'b1; f1[31] = 1'b1; f1[32] = 1'b1; f1[100] = 1'b1;
        run_frame(f1, 1'b0, 1'b0, 1000);

        // All-ones first chunk.
        fr = '0;
        fr[31:0] = '1;
        run_frame(fr, 1'b0, 1'b0, 1000);

        // Backpressure with a competing input held valid during the frame.
        run_frame(f1, 1'b1, 1'b1, 1000);
        run_frame(f1, 1'b1, 1'b0, 1000);

        // Random frames of varying density.
        for (int k = 0; k < 8; k++) begin
            for (int w = 0; w < CHUNK_NUM; w++) begin
                logic [31:0] word;
                word = $urandom();
                if (k % 3 == 1) word = word & $urandom() & $urandom();
                if (k % 3 == 2) word = word | $urandom();
                fr[32*w +: 32] = word;
            end
            run_frame(fr, k[0], k[1], 1000);
        end

        // Reset mid-frame after three tokens.
        run_frame(f1, 1'b0, 1'b0, 3);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(opt_valid), 32'd0);
        check("midrst_ready", 32'(ipt_ready), 32'd1);
        check("midrst_enc", 32'(enc), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        fr = '0;
        fr[1] = 1'b1;
        run_frame(fr, 1'b0, 1'b0, 1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
